// File: rtl/spi_master.sv
// SPI master issuing 3-byte register frames {slave id, address, data}, MSB first.
// It samples miso during the data byte of read frames and holds ss high for a guard gap after every frame.
module spi_master #(
    parameter int unsigned SCLK_HALF = 8,
    parameter int unsigned GUARD     = 24,
    parameter logic [7:0]  SLAVE_IDW = 8'hFF,
    parameter logic [7:0]  SLAVE_IDR = 8'h00
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned HALF_W     = $clog2(SCLK_HALF);
    localparam int unsigned GUARD_W    = $clog2(GUARD);
    localparam int unsigned FRAME_BITS = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GUARD
    } state_e;

    state_e                  state_q, state_d;
    logic [HALF_W-1:0]       half_cnt_q, half_cnt_d;
    logic [GUARD_W-1:0]      guard_cnt_q, guard_cnt_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic                    rw_q, rw_d;
    logic [7:0]              cap_q, cap_d;
    logic                    ss_q, ss_d;
    logic                    sclk_q, sclk_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    half_end_c;
    logic                    guard_end_c;

    assign half_end_c  = (half_cnt_q == HALF_W'(SCLK_HALF - 1));
    assign guard_end_c = (guard_cnt_q == GUARD_W'(GUARD - 1));

    // State and output registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            half_cnt_q  <= '0;
            guard_cnt_q <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            rw_q        <= 1'b0;
            cap_q       <= '0;
            ss_q        <= 1'b1;
            sclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            rw_q        <= rw_d;
            cap_q       <= cap_d;
            ss_q        <= ss_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic. mosi is the shift register MSB; zero fill leaves mosi low after the last bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        rw_d      = rw_q;
        cap_d     = cap_q;
        ss_d      = ss_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = {rw ? SLAVE_IDR : SLAVE_IDW, addr, rw ? 8'h00 : wdata};
                    rw_d    = rw;
                    cap_d   = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (half_end_c) begin
                    sclk_d  = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (half_cnt_q == '0 && rw_q && bit_cnt_q[4:3] == 2'd2) begin
                    cap_d = {cap_q[6:0], miso};
                end
                if (half_end_c) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    sr_d      = {sr_q[FRAME_BITS-2:0], 1'b0};
                    state_d   = S_LOW;
                end
            end
            S_LOW: begin
                // bit_cnt reaches FRAME_BITS only during the final LOW phase.
                if (half_end_c) begin
                    if (bit_cnt_q == 5'(FRAME_BITS)) begin
                        ss_d      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_GUARD;
                    end else begin
                        sclk_d  = 1'b1;
                        state_d = S_HIGH;
                    end
                end
            end
            S_GUARD: begin
                if (guard_end_c) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (rw_q) begin
                        rdata_d = cap_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        half_cnt_d  = (state_d == state_q && state_q != S_IDLE && state_q != S_GUARD)
                      ? half_cnt_q + HALF_W'(1) : '0;
        guard_cnt_d = (state_d == S_GUARD && state_q == S_GUARD)
                      ? guard_cnt_q + GUARD_W'(1) : '0;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign ss    = ss_q;
    assign sclk  = sclk_q;
    assign mosi  = sr_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: random and directed frames against a register-map reference model, with an SPI slave responder.
module tb_spi_master;

    localparam int unsigned SCLK_HALF = 8;
    localparam int unsigned GUARD     = 24;
    localparam int unsigned LAT       = 1 + 49 * SCLK_HALF + GUARD;
    localparam int unsigned SS_LOW    = 49 * SCLK_HALF;

    typedef struct {
        int          acc_cyc;
        logic [23:0] frame;
        logic [7:0]  rdata;
        bit          b2b;
    } exp_t;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       miso = 1'b0;
    logic       busy, done, ss, sclk, mosi;
    logic [7:0] rdata;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    logic [7:0] ref_regs[4] = '{default: 8'h00};
    logic [7:0] ref_rdata = 8'h00;

    // Bus-side observations shared with the scoreboard.
    int          s_rises = 0, last_rises = 0, last_low = 0, last_gap = 0;
    int          low_start = 0, ss_rise_cyc = 0, viol = 0, busy_rise_cyc = 0, busy_hi = 0, s_dly = 0;
    logic [23:0] s_frame = '0, last_frame = '0;
    logic [7:0]  rd_byte = 8'h00;
    bit          rd_en = 1'b0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, busy_prev = 1'b0;
    logic [7:0]  slave_regs[4] = '{default: 8'h00};

    spi_master #(.SCLK_HALF(SCLK_HALF), .GUARD(GUARD)) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .ss      (ss),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit mapped(input logic [7:0] a);
        return (a >= 8'h10 && a <= 8'h13);
    endfunction

    // Slave responder and bus-rule monitor, sampling away from the rising edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!n_reset) begin
                s_rises = 0; s_frame = '0; s_dly = 0; rd_en = 1'b0; miso = 1'b0;
                prev_ss = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; busy_prev = 1'b0;
                slave_regs = '{default: 8'h00};
                continue;
            end
            if (sclk && ss) viol++;
            if (sclk && prev_sclk && mosi != prev_mosi) viol++;
            if (busy && !busy_prev) begin busy_rise_cyc = cyc; busy_hi = 0; end
            if (busy) busy_hi++;
            if (!ss && prev_ss) begin
                last_gap = cyc - ss_rise_cyc; low_start = cyc;
                s_rises = 0; s_frame = '0; rd_en = 1'b0;
            end
            if (ss && !prev_ss) begin
                ss_rise_cyc = cyc; last_low = cyc - low_start;
                last_frame = s_frame; last_rises = s_rises;
                if (s_rises == 24 && s_frame[23:16] == 8'hFF && mapped(s_frame[15:8]))
                    slave_regs[s_frame[9:8]] = s_frame[7:0];
            end
            if (!ss && sclk && !prev_sclk) begin
                s_frame = {s_frame[22:0], mosi};
                s_rises++;
            end
            if (!ss && !sclk && prev_sclk) begin
                s_dly = 4;
            end else if (s_dly != 0) begin
                s_dly--;
                if (s_dly == 0) begin
                    if (s_rises == 16) begin
                        rd_en   = (s_frame[15:8] == 8'h00);
                        rd_byte = (rd_en && mapped(s_frame[7:0])) ? slave_regs[s_frame[1:0]] : 8'h00;
                    end
                    miso = (rd_en && s_rises >= 16 && s_rises <= 23) ? rd_byte[3'(23 - s_rises)] : 1'b0;
                end
            end
            prev_ss = ss; prev_sclk = sclk; prev_mosi = mosi; busy_prev = busy;
        end
    end

    // Scoreboard: every done pulse retires the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (n_reset && done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_latency", 32'(cyc - e.acc_cyc), LAT);
                    check("mosi_frame", 32'(last_frame), 32'(e.frame));
                    check("sclk_rises", 32'(last_rises), 32'd24);
                    check("ss_low_cycles", 32'(last_low), SS_LOW);
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("busy_rise", 32'(busy_rise_cyc - e.acc_cyc), 32'd1);
                    check("busy_cycles", 32'(busy_hi), LAT - 1);
                    check("bus_rules", 32'(viol), 32'd0);
                    if (e.b2b) check("ss_gap", 32'(last_gap), GUARD + 1);
                end
            end
        end
    end

    task automatic issue(input bit r, input logic [7:0] a, input logic [7:0] d, input bit b2b, input int hold);
        exp_t e;
        bit   ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            ok = b2b ? done : (!busy && exp_q.size() == 0);
        end
        if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clock);
        check("issue_wait", 32'(ok), 32'd1);
        start = 1'b1; rw = r; addr = a; wdata = d;
        e.acc_cyc = cyc;
        e.frame   = {r ? 8'h00 : 8'hFF, a, r ? 8'h00 : d};
        e.b2b     = b2b;
        if (!r && mapped(a)) ref_regs[a[1:0]] = d;
        if (r) ref_rdata = mapped(a) ? ref_regs[a[1:0]] : 8'h00;
        e.rdata = ref_rdata;
        exp_q.push_back(e);
        repeat (hold) begin
            @(negedge clock);
            rw = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            ok = (!busy && exp_q.size() == 0);
        end
        check("idle_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        bit         r;
        logic [7:0] a;
        bit         ok;

        repeat (3) @(negedge clock);
        check("reset_ss", 32'(ss), 32'd1);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        n_reset = 1'b1;
        repeat (2) @(negedge clock);

        issue(1'b0, 8'h10, 8'hA5, 1'b0, 0);
        issue(1'b1, 8'h10, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h13, 8'h3C, 1'b0, 0);
        issue(1'b1, 8'h13, 8'h00, 1'b0, 0);
        issue(1'b1, 8'h20, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h11, 8'h5A, 1'b0, 0);
        issue(1'b0, 8'h12, 8'hC3, 1'b0, 300);
        issue(1'b1, 8'h12, 8'h00, 1'b1, 0);
        issue(1'b0, 8'h10, 8'h77, 1'b1, 0);

        for (int i = 0; i < 10; i++) begin
            r = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h10 + $urandom_range(0, 3));
            issue(r, a, 8'($urandom), ($urandom_range(0, 3) == 0), 0);
        end

        issue(1'b0, 8'h11, 8'h96, 1'b0, 0);
        issue(1'b1, 8'h11, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h12, 8'hE7, 1'b0, 0);
        repeat (2) @(negedge clock);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            ok = (s_rises >= 10);
        end
        check("reach_byte1", 32'(ok), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        check("midreset_ss", 32'(ss), 32'd1);
        check("midreset_sclk", 32'(sclk), 32'd0);
        check("midreset_mosi", 32'(mosi), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_rdata", 32'(rdata), 32'd0);
        exp_q.delete();
        ref_regs  = '{default: 8'h00};
        ref_rdata = 8'h00;
        repeat (5) @(negedge clock);
        n_reset = 1'b1;
        repeat (450) @(negedge clock);

        issue(1'b0, 8'h10, 8'h5C, 1'b0, 0);
        issue(1'b1, 8'h10, 8'h00, 1'b0, 0);
        issue(1'b1, 8'h12, 8'h00, 1'b0, 0);
        wait_idle();
        repeat (5) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
